// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: frames preamble/payload/gap onto a registered AXIS output for the PSK modulator
// Ports: clk, rst_n (async active-low); enable, cfg_bpsk (framing control);
// s_tdata/s_tvalid/s_tready (payload source); m_tdata/m_tvalid/m_tready/m_tlast/m_tuser
// (modulator output, tuser = is_bpsk); busy (not IDLE); frame_cnt (completed frames).
module tx_frame_ctrl #(
    parameter int BYTES        = 1,
    parameter int PREAMBLE_LEN = 32,
    parameter int PAYLOAD_LEN  = 256,
    parameter int GAP_LEN      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 cfg_bpsk,
    input  logic [BYTES*8-1:0]   s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    output logic [BYTES*8-1:0]   m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic                 m_tuser,
    output logic                 busy,
    output logic [15:0]          frame_cnt
);
    localparam int BITS = BYTES * 8;
    localparam int MAXC = (PREAMBLE_LEN > PAYLOAD_LEN)
                        ? ((PREAMBLE_LEN > GAP_LEN + 1) ? PREAMBLE_LEN : GAP_LEN + 1)
                        : ((PAYLOAD_LEN > GAP_LEN + 1) ? PAYLOAD_LEN : GAP_LEN + 1);
    localparam int CW = (MAXC < 2) ? 1 : $clog2(MAXC);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              mode, mode_n;
    logic [BITS-1:0]   tdata_n;
    logic              tvalid_n, tuser_n, tlast_n;
    logic              load;

    assign load     = !m_tvalid || m_tready;
    assign s_tready = (state == PAYLOAD) && load;
    assign busy     = state != IDLE;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        mode_n   = mode;
        tdata_n  = m_tdata;
        tuser_n  = m_tuser;
        tlast_n  = m_tlast;
        tvalid_n = m_tvalid && !m_tready;
        case (state)
            IDLE: if (enable) begin
                state_n = PREAMBLE;
                mode_n  = cfg_bpsk;
            end
            PREAMBLE: if (load) begin
                tvalid_n   = 1'b1;
                tdata_n    = '0;
                tdata_n[1] = ~cnt[0];
                tuser_n    = 1'b1;
                tlast_n    = 1'b0;
                state_n    = (cnt == CW'(PREAMBLE_LEN - 1)) ? PAYLOAD : PREAMBLE;
                cnt_n      = (cnt == CW'(PREAMBLE_LEN - 1)) ? '0 : cnt + CW'(1);
            end
            PAYLOAD: if (s_tvalid && s_tready) begin
                tvalid_n = 1'b1;
                tdata_n  = s_tdata;
                tuser_n  = mode;
                tlast_n  = cnt == CW'(PAYLOAD_LEN - 1);
                state_n  = tlast_n ? GAP : PAYLOAD;
                cnt_n    = tlast_n ? '0 : cnt + CW'(1);
            end
            GAP: if (!m_tvalid) begin
                // gap counting starts only once the tlast beat has left the output register
                if (cnt == CW'(GAP_LEN)) begin
                    cnt_n   = '0;
                    state_n = enable ? PREAMBLE : IDLE;
                    mode_n  = enable ? cfg_bpsk : mode;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mode      <= 1'b0;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tuser   <= 1'b0;
            m_tlast   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            mode      <= mode_n;
            m_tvalid  <= tvalid_n;
            m_tdata   <= tdata_n;
            m_tuser   <= tuser_n;
            m_tlast   <= tlast_n;
            frame_cnt <= frame_cnt + 16'(m_tvalid && m_tready && m_tlast);
        end
    end
endmodule

// File: tb/tb_tx_frame_ctrl.sv
// tb_tx_frame_ctrl: randomized scoreboard bench for tx_frame_ctrl plus a GAP_LEN=0 wrap instance
module tb_tx_frame_ctrl;
    localparam int PRE = 4;
    localparam int PAY = 8;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       enable = 1'b0, cfg_bpsk = 1'b0, s_tvalid = 1'b0, m_tready = 1'b1;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tready, m_tvalid, m_tlast, m_tuser, busy;
    logic [7:0] m_tdata;
    logic [15:0] frame_cnt;

    logic       b_sready, b_tvalid, b_tlast, b_tuser, b_busy;
    logic [7:0] b_tdata;
    logic [15:0] b_fc;

    tx_frame_ctrl #(.BYTES(1), .PREAMBLE_LEN(PRE), .PAYLOAD_LEN(PAY), .GAP_LEN(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_bpsk(cfg_bpsk),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser), .busy(busy), .frame_cnt(frame_cnt)
    );

    tx_frame_ctrl #(.BYTES(1), .PREAMBLE_LEN(2), .PAYLOAD_LEN(3), .GAP_LEN(0)) dutb (
        .clk(clk), .rst_n(rst_n), .enable(1'b1), .cfg_bpsk(1'b1),
        .s_tdata(8'hA5), .s_tvalid(1'b1), .s_tready(b_sready),
        .m_tdata(b_tdata), .m_tvalid(b_tvalid), .m_tready(1'b1),
        .m_tlast(b_tlast), .m_tuser(b_tuser), .busy(b_busy), .frame_cnt(b_fc)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // expected beats as {last, user, data}; source words in offer order
    logic [9:0] exp_q[$];
    logic [7:0] src_q[$];

    int fi, wi, bn, starve, fc_exp;
    bit hs, rdy_rand, stv_en;

    task automatic start_frame(input logic c);
        logic [7:0] w;
        for (int k = 0; k < PRE; k++) exp_q.push_back({1'b0, 1'b1, (k % 2 == 0) ? 8'h02 : 8'h00});
        for (int j = 0; j < PAY; j++) begin
            w = 8'($urandom);
            src_q.push_back(w);
            exp_q.push_back({j == PAY - 1, c, w});
        end
    endtask

    task automatic cycle();
        logic c;
        @(negedge clk);
        m_tready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (!(s_tvalid && !hs)) begin
            if (starve > 0) begin
                starve--;
                s_tvalid = 1'b0;
            end else if (stv_en && $urandom_range(0, 9) == 0) begin
                starve = 4;
                s_tvalid = 1'b0;
            end else if (src_q.size() > 0) begin
                s_tvalid = 1'b1;
                s_tdata = src_q[0];
            end else begin
                s_tvalid = 1'b0;
            end
            if (!s_tvalid) s_tdata = 8'($urandom);
        end
        #1;
        hs = s_tvalid && s_tready;
        if (hs) begin
            void'(src_q.pop_front());
            wi++;
            if (wi == 3) begin
                if (fi + 1 < bn) begin
                    c = 1'($urandom);
                    cfg_bpsk = c;
                    start_frame(c);
                end else begin
                    enable = 1'b0;
                    cfg_bpsk = ~cfg_bpsk;
                end
            end
            if (wi == PAY) begin
                wi = 0;
                fi++;
            end
        end
    endtask

    task automatic begin_batch(input int n, input bit rr, input bit se, input logic c);
        bn = n; fi = 0; wi = 0; starve = 0;
        rdy_rand = rr; stv_en = se;
        cfg_bpsk = c;
        start_frame(c);
        enable = 1'b1;
    endtask

    task automatic run_batch(input int n, input bit rr, input bit se, input logic c);
        begin_batch(n, rr, se, c);
        for (int i = 0; i < 5000; i++) begin
            cycle();
            if (!busy && !m_tvalid && exp_q.size() == 0 && fi == bn) break;
        end
        check("batch_idle", {30'd0, busy, m_tvalid}, 32'd0);
        check("batch_drained", exp_q.size(), 32'd0);
        fc_exp += n;
        check("frame_cnt", frame_cnt, fc_exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, m_tvalid, 0);
        check({tag, "_tdata"}, m_tdata, 0);
        check({tag, "_tuser"}, m_tuser, 0);
        check({tag, "_tlast"}, m_tlast, 0);
        check({tag, "_s_tready"}, s_tready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    task automatic b_wait_last();
        bit found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            found = b_tvalid && b_tlast;
        end
        check("b_tlast_seen", found, 1);
        check("b_last_beat", {b_tuser, b_tdata}, {1'b1, 8'hA5});
        check("b_s_tready_gap", b_sready, 0);
    endtask

    task automatic b_gap();
        int g = 0;
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = b_tvalid;
            if (!seen) g++;
        end
        check("b_gap_cycles", g, 2);
    endtask

    // monitor: pops the scoreboard on every output handshake, checks stalls and gap length
    initial begin
        bit stl = 0, ingap = 0, gap_en = 0;
        logic [9:0] held = '0, e;
        int gcnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stl = 0;
                ingap = 0;
            end else begin
                if (stl) check("stall_hold", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, held});
                stl = m_tvalid && !m_tready;
                held = {m_tlast, m_tuser, m_tdata};
                if (stl) check("s_tready_stalled", s_tready, 0);
                if (ingap) begin
                    if (m_tvalid) begin
                        if (gap_en) check("gap_cycles", gcnt, GAP + 2);
                        ingap = 0;
                    end else begin
                        gcnt++;
                        gap_en &= enable;
                    end
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", {m_tlast, m_tuser, m_tdata}, 32'hFFFFFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {m_tlast, m_tuser, m_tdata}, e);
                    end
                    if (m_tlast) begin
                        ingap = 1;
                        gcnt = 0;
                        gap_en = enable;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        hs = 0; starve = 0; fc_exp = 0; fi = 0; wi = 0; bn = 0;
        rdy_rand = 0; stv_en = 0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_batch(2, 0, 0, 1'b0);
        run_batch(4, 1, 1, 1'b0);
        run_batch(2, 0, 0, 1'b1);
        run_batch(3, 1, 1, 1'($urandom));

        begin_batch(2, 1, 0, 1'b1);
        for (int i = 0; i < 500 && !(fi == 0 && wi == 3); i++) cycle();
        check("reached_payload3", wi, 3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        enable = 1'b0;
        exp_q.delete();
        src_q.delete();
        s_tvalid = 1'b0;
        hs = 0;
        fc_exp = 0;
        #1;
        check_reset_outputs("midframe_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_batch(3, 1, 1, 1'b0);

        check("b_busy", b_busy, 1);
        b_wait_last();
        b_gap();
        b_wait_last();
        b_gap();
        b_wait_last();
        @(negedge clk);
        force dutb.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dutb.frame_cnt;
        #1;
        check("b_fc_preload", b_fc, 16'hFFFF);
        b_wait_last();
        check("b_fc_before_wrap", b_fc, 16'hFFFF);
        @(negedge clk);
        #1;
        check("b_fc_wrap", b_fc, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tx_frame_ctrl.md
# tx_frame_ctrl

Transmit frame controller between the PN/payload data source and the PSK modulator's AXIS input. Sequences each frame as a fixed BPSK preamble, a payload of PAYLOAD_LEN beats pulled from the upstream AXIS source, and an idle gap. Drives per-frame modulation select on `tuser` and frame end on `tlast`. Owns a registered AXIS output stage and a frame counter.

## Interface
- `BYTES`, 1: AXIS word width in bytes (BITS = BYTES*8, BITS ≥ 8).
- `PREAMBLE_LEN`, 32: preamble beats per frame (≥ 1).
- `PAYLOAD_LEN`, 256: payload beats per frame (≥ 1).
- `GAP_LEN`, 16: gap length parameter (≥ 0); see Timing.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  start/continue framing; sampled in IDLE and at gap end.
- `cfg_bpsk`  in  1  payload modulation for next frame (1 = BPSK, 0 = QPSK); latched at frame start.
- `s_tdata`  in  BITS  payload data from source.
- `s_tvalid`  in  1  payload valid.
- `s_tready`  out  1  payload accepted when high with `s_tvalid`.
- `m_tdata`  out  BITS  frame data to modulator.
- `m_tvalid`  out  1  output valid.
- `m_tready`  in  1  modulator ready.
- `m_tlast`  out  1  last payload beat of frame.
- `m_tuser`  out  1  is_bpsk for the current beat.
- `busy`  out  1  high in any state other than IDLE.
- `frame_cnt`  out  16  completed frames, wraps 0xFFFF→0.

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, GAP. One beat counter `cnt`, cleared on every state change.
- Output register loads ("load") at an edge where `!m_tvalid || m_tready`. If no new beat is loaded while `m_tready` is high, `m_tvalid` clears.
- IDLE: when `enable`=1, go to PREAMBLE and latch `cfg_bpsk` into `mode`. `s_tready`=0.
- PREAMBLE: each load emits preamble beat k = `cnt`.
  - `m_tdata` has bit1 = ~k[0] (1,0,1,0…) and all other bits 0.
  - `m_tuser`=1 (always BPSK) and `m_tlast`=0.
  - The load of beat PREAMBLE_LEN-1 moves the state to PAYLOAD.
- PAYLOAD: `s_tready` = `!m_tvalid || m_tready` (combinational; 0 in all other states).
  - Each upstream handshake loads `m_tdata`=`s_tdata`, `m_tuser`=`mode`, and `cnt`++.
  - The beat at `cnt`=PAYLOAD_LEN-1 loads with `m_tlast`=1 and moves the state to GAP.
  - If `s_tvalid`=0, nothing loads; the output drains (bubble). The frame is never truncated.
- GAP: `s_tready`=0.
  - While `m_tvalid`=1 (tlast beat pending), hold.
  - Once `m_tvalid`=0: if `cnt`==GAP_LEN, transition; else `cnt`++.
  - Transition goes to PREAMBLE (re-latching `cfg_bpsk`) if `enable`=1, else to IDLE.
- `frame_cnt` increments on the edge where `m_tvalid && m_tready && m_tlast`.
- `enable` deasserted mid-frame has no effect until the gap ends; the current frame always completes.
- Counter widths are sized for max(PREAMBLE_LEN, PAYLOAD_LEN, GAP_LEN+1); no overflow within a state.
- Backpressure: `m_tdata`/`m_tuser`/`m_tlast` are held stable while `m_tvalid && !m_tready`.

## Timing
- Reset (async assert, sync deassert by the environment) forces:
  - state IDLE, `cnt`=0, `mode`=0;
  - `m_tvalid`=0, `m_tdata`=0, `m_tuser`=0, `m_tlast`=0;
  - `s_tready`=0, `busy`=0, `frame_cnt`=0.
- Reset mid-frame discards the frame with no `tlast` and no count increment.
- Start latency: `enable` sampled high at edge E0 → PREAMBLE at E0. First preamble beat is valid after E0+1.
- Throughput: with `m_tready`=1 and `s_tvalid`=1 continuously, PREAMBLE_LEN + PAYLOAD_LEN beats are contiguous (no bubble at the preamble/payload boundary).
- Payload latency: upstream handshake at edge E → beat on `m_tdata` valid from E, 1 register stage.
- Gap: with `m_tready`=1, `m_tvalid` is low for exactly GAP_LEN+2 cycles between the `tlast` handshake and the next first preamble beat.

## Test plan
- **Basic frame**: PREAMBLE_LEN=4, PAYLOAD_LEN=8, GAP_LEN=2; `enable`=1, `cfg_bpsk`=0, source sends 0x01..0x08 with `m_tready`=1.
  - Output: 0x02,0x00,0x02,0x00 with `tuser`=1, then 0x01..0x08 with `tuser`=0 and `tlast` on 0x08.
  - Then 4 idle cycles; `frame_cnt`=1.
- **Backpressure**: toggle `m_tready` 1-0-1-0 during payload. No beat is lost or duplicated, data is stable while stalled, and `s_tready` is low whenever `m_tvalid && !m_tready`.
- **Source starvation**: `s_tvalid` low for 5 cycles mid-payload. Output bubbles, the frame still totals 8 payload beats, and `tlast` appears only on the 8th.
- **Mode latch and enable drop**: change `cfg_bpsk` 0→1 and drop `enable` during frame 1.
  - Frame 1 completes with `tuser`=0 on payload.
  - Controller returns to IDLE and `busy`=0.
  - Re-enable → frame 2 payload has `tuser`=1.
- **Reset mid-payload**: assert `rst_n`=0 at payload beat 3. All outputs go to reset values immediately and `frame_cnt` is unchanged (0). After release with `enable`=1, a full preamble restarts.
- **Wrap / GAP_LEN=0**: preload `frame_cnt`=0xFFFF via forced run, then complete one frame → 0x0000. With GAP_LEN=0, the idle interval between frames is 2 cycles.
